// File: rtl/light_countdown_pkg.sv
// Shared encodings and 7-segment constants for the traffic-light countdown display.
// The light controller can import the same package to share the phase encoding.
package light_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_e;

    // Active-low segment codes, bit0 = seg a ... bit6 = seg g, bit7 = dp (off).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [9:0][7:0] SEG_DIGITS = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] to_bcd(input int unsigned val);
        return {4'(val / 10), 4'(val % 10)};
    endfunction

    // Two-digit BCD decrement that saturates at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] bcd);
        if (bcd == 8'h00) begin
            return bcd;
        end
        if (bcd[3:0] == 4'd0) begin
            return {bcd[7:4] - 4'd1, 4'd9};
        end
        return {bcd[7:4], bcd[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/light_countdown_seg7_dec.sv
// BCD digit to active-low 7-segment code; non-decimal inputs show blank.
module seg7_dec
    import light_countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) begin
            seg = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/light_countdown.sv
// Countdown of the remaining phase time for a traffic light, shown as two BCD
// digits on 7-segment displays, with hold (stop) and phase-input fault handling.
module light_countdown
    import light_countdown_pkg::*;
#(
    parameter int unsigned T_GREEN  = 6,
    parameter int unsigned T_YELLOW = 2,
    parameter int unsigned T_RED    = 9
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       tick,
    input  logic       x,
    input  logic       v,
    input  logic       d,
    input  logic       stop,
    output logic [7:0] cnt,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic       fault
);

    localparam logic [7:0] GREEN_BCD  = to_bcd(T_GREEN);
    localparam logic [7:0] YELLOW_BCD = to_bcd(T_YELLOW);
    localparam logic [7:0] RED_BCD    = to_bcd(T_RED);

    state_e     state_q, state_d;
    phase_e     phase_q, phase_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] inv_q,   inv_d;
    logic       fault_q, fault_d;

    logic       phase_valid;
    phase_e     phase_in;
    logic [7:0] ones_seg, tens_seg;

    function automatic logic [7:0] load_value(input phase_e ph);
        case (ph)
            PH_GREEN:  return GREEN_BCD;
            PH_YELLOW: return YELLOW_BCD;
            default:   return RED_BCD;
        endcase
    endfunction

    always_comb begin
        phase_valid = $onehot({x, v, d});
        if (x) begin
            phase_in = PH_GREEN;
        end else if (v) begin
            phase_in = PH_YELLOW;
        end else begin
            phase_in = PH_RED;
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;

        if (!phase_valid) begin
            inv_d = (inv_q == 2'd2) ? inv_q : inv_q + 2'd1;
            // A lone invalid cycle is a glitch; the second one in a row is a fault.
            if (inv_q != 2'd0) begin
                state_d = ST_FAULT;
                cnt_d   = 8'h00;
                phase_d = PH_NONE;
            end
        end else begin
            inv_d = 2'd0;
            unique case (state_q)
                ST_FAULT: state_d = ST_IDLE;
                ST_HOLD: begin
                    if (!stop) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (phase_in != phase_q) begin
                        cnt_d   = load_value(phase_in);
                        phase_d = phase_in;
                        state_d = ST_RUN;
                    end else if (state_q == ST_RUN) begin
                        if (stop && d) begin
                            state_d = ST_HOLD;
                        end else if (tick) begin
                            cnt_d = bcd_dec(cnt_q);
                        end
                    end
                end
            endcase
        end

        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge ck) begin
        // NOTE: reset is sampled on the clock edge, and all state uses non-blocking assignment so every flop sees pre-edge values.
        if (!rs) begin
            state_q <= ST_IDLE;
            phase_q <= PH_NONE;
            cnt_q   <= 8'h00;
            inv_q   <= 2'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            fault_q <= fault_d;
        end
    end

    seg7_dec u_ones (
        .bcd (cnt_q[3:0]),
        .seg (ones_seg)
    );

    seg7_dec u_tens (
        .bcd (cnt_q[7:4]),
        .seg (tens_seg)
    );

    always_comb begin
        HEX0 = SEG_BLANK;
        HEX1 = SEG_BLANK;
        case (state_q)
            ST_RUN: begin
                HEX0 = ones_seg;
                HEX1 = (cnt_q[7:4] == 4'd0) ? SEG_BLANK : tens_seg;
            end
            ST_HOLD: begin
                HEX0 = SEG_DASH;
                HEX1 = SEG_DASH;
            end
            default: begin
                HEX0 = SEG_BLANK;
                HEX1 = SEG_BLANK;
            end
        endcase
    end

    assign cnt   = cnt_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_light_countdown.sv
// Directed scenarios plus a randomized run against an integer-based model,
// on two instances: default timings (a) and T_RED=12 (b).
module tb_light_countdown;

    logic ck = 1'b0;
    logic rs = 1'b0, tick = 1'b0, x = 1'b0, v = 1'b0, d = 1'b0, stop = 1'b0;
    logic [7:0] cnt_a, hex0_a, hex1_a, cnt_b, hex0_b, hex1_b;
    logic fault_a, fault_b;
    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_FAULT = 3;
    int m_mode [2];
    int m_rem [2];
    int m_ph [2];
    int m_streak [2];
    int m_dur [2][4] = '{'{0, 6, 2, 9}, '{0, 6, 2, 12}};

    always #5 ck = ~ck;

    light_countdown dut_a (
        .ck(ck), .rs(rs), .tick(tick), .x(x), .v(v), .d(d), .stop(stop),
        .cnt(cnt_a), .HEX0(hex0_a), .HEX1(hex1_a), .fault(fault_a)
    );

    light_countdown #(.T_RED(12)) dut_b (
        .ck(ck), .rs(rs), .tick(tick), .x(x), .v(v), .d(d), .stop(stop),
        .cnt(cnt_b), .HEX0(hex0_b), .HEX1(hex1_b), .fault(fault_b)
    );

    task automatic clk_cycle();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rs = 1'b0; x = 1'b0; v = 1'b0; d = 1'b0; stop = 1'b0; tick = 1'b0;
        repeat (2) clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h00, 8'hFF, 8'hFF, 1'b0})
            $display("FAIL reset_a: got %h/%h/%h/%b want 00/FF/FF/0", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
        n_checks++;
        if ({cnt_b, hex1_b, hex0_b, fault_b} !== {8'h00, 8'hFF, 8'hFF, 1'b0})
            $display("FAIL reset_b: got %h/%h/%h/%b want 00/FF/FF/0", cnt_b, hex1_b, hex0_b, fault_b);
        else n_pass++;
        rs = 1'b1; x = 1'b1;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h06, 8'hFF, 8'h82, 1'b0})
            $display("FAIL green_load: got %h/%h/%h/%b want 06/FF/82/0", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
    endtask

    task automatic test_countdown();
        for (int i = 5; i >= 0; i--) begin
            tick = 1'b1;
            clk_cycle();
            n_checks++;
            if ({cnt_a, hex1_a, hex0_a} !== {4'd0, 4'(i), 8'hFF, seg_tbl[i]})
                $display("FAIL countdown_%0d: got %h/%h/%h want %0d", i, cnt_a, hex1_a, hex0_a, i);
            else n_pass++;
        end
        clk_cycle();
        tick = 1'b0;
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a} !== {8'h00, 8'hFF, 8'hC0})
            $display("FAIL saturate: got %h/%h/%h want 00/FF/C0", cnt_a, hex1_a, hex0_a);
        else n_pass++;
    endtask

    task automatic test_phase_priority();
        x = 1'b0; v = 1'b1;
        clk_cycle();
        x = 1'b1; v = 1'b0;
        clk_cycle();
        tick = 1'b1;
        repeat (3) clk_cycle();
        tick = 1'b0;
        n_checks++;
        if ({cnt_a, hex0_a} !== {8'h03, 8'hB0})
            $display("FAIL pre_change: got %h/%h want 03/B0", cnt_a, hex0_a);
        else n_pass++;
        x = 1'b0; v = 1'b1; tick = 1'b1;
        clk_cycle();
        tick = 1'b0;
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h02, 8'hFF, 8'hA4, 1'b0})
            $display("FAIL change_beats_tick: got %h/%h/%h/%b want 02/FF/A4/0", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
        clk_cycle();
    endtask

    task automatic test_red_two_digit();
        logic [7:0] exp_cnt [3] = '{8'h11, 8'h10, 8'h09};
        logic [7:0] exp_h1 [3] = '{8'hF9, 8'hF9, 8'hFF};
        logic [7:0] exp_h0 [3] = '{8'hF9, 8'hC0, 8'h90};
        v = 1'b0; d = 1'b1;
        clk_cycle();
        n_checks++;
        if ({cnt_b, hex1_b, hex0_b} !== {8'h12, 8'hF9, 8'hA4})
            $display("FAIL red12_load: got %h/%h/%h want 12/F9/A4", cnt_b, hex1_b, hex0_b);
        else n_pass++;
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a} !== {8'h09, 8'hFF, 8'h90})
            $display("FAIL red9_load: got %h/%h/%h want 09/FF/90", cnt_a, hex1_a, hex0_a);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            clk_cycle();
            n_checks++;
            if ({cnt_b, hex1_b, hex0_b} !== {exp_cnt[i], exp_h1[i], exp_h0[i]})
                $display("FAIL red12_tick%0d: got %h/%h/%h want %h/%h/%h", i, cnt_b, hex1_b, hex0_b,
                         exp_cnt[i], exp_h1[i], exp_h0[i]);
            else n_pass++;
        end
        tick = 1'b0;
    endtask

    task automatic test_hold();
        x = 1'b1; d = 1'b0;
        clk_cycle();
        x = 1'b0; d = 1'b1;
        clk_cycle();
        tick = 1'b1;
        repeat (2) clk_cycle();
        tick = 1'b0; stop = 1'b1;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a} !== {8'h07, 8'hBF, 8'hBF})
            $display("FAIL hold_enter: got %h/%h/%h want 07/BF/BF", cnt_a, hex1_a, hex0_a);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            clk_cycle();
            n_checks++;
            if ({cnt_a, hex1_a, hex0_a} !== {8'h07, 8'hBF, 8'hBF})
                $display("FAIL hold_tick%0d: got %h/%h/%h want 07/BF/BF", i, cnt_a, hex1_a, hex0_a);
            else n_pass++;
        end
        n_checks++;
        if ({cnt_b, hex1_b, hex0_b} !== {8'h10, 8'hBF, 8'hBF})
            $display("FAIL hold_b: got %h/%h/%h want 10/BF/BF", cnt_b, hex1_b, hex0_b);
        else n_pass++;
        tick = 1'b0; stop = 1'b0;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a} !== {8'h07, 8'hFF, 8'hF8})
            $display("FAIL hold_release: got %h/%h/%h want 07/FF/F8", cnt_a, hex1_a, hex0_a);
        else n_pass++;
        tick = 1'b1;
        clk_cycle();
        tick = 1'b0;
        n_checks++;
        if ({cnt_a, hex0_a} !== {8'h06, 8'h82})
            $display("FAIL after_hold_tick: got %h/%h want 06/82", cnt_a, hex0_a);
        else n_pass++;
        stop = 1'b1;
        clk_cycle();
        stop = 1'b0; tick = 1'b1;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex0_a} !== {8'h06, 8'h82})
            $display("FAIL release_tick_ignored: got %h/%h want 06/82", cnt_a, hex0_a);
        else n_pass++;
        clk_cycle();
        tick = 1'b0;
        n_checks++;
        if ({cnt_a, hex0_a} !== {8'h05, 8'h92})
            $display("FAIL release_next_tick: got %h/%h want 05/92", cnt_a, hex0_a);
        else n_pass++;
    endtask

    task automatic test_fault();
        x = 1'b1; v = 1'b1; d = 1'b0;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h05, 8'hFF, 8'h92, 1'b0})
            $display("FAIL glitch: got %h/%h/%h/%b want 05/FF/92/0", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
        x = 1'b0; v = 1'b0; d = 1'b1;
        clk_cycle();
        x = 1'b1; v = 1'b1; d = 1'b0;
        clk_cycle();
        n_checks++;
        if ({cnt_a, fault_a} !== {8'h05, 1'b0})
            $display("FAIL fault_first: got %h/%b want 05/0", cnt_a, fault_a);
        else n_pass++;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h00, 8'hFF, 8'hFF, 1'b1})
            $display("FAIL fault_a: got %h/%h/%h/%b want 00/FF/FF/1", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
        n_checks++;
        if ({cnt_b, hex1_b, hex0_b, fault_b} !== {8'h00, 8'hFF, 8'hFF, 1'b1})
            $display("FAIL fault_b: got %h/%h/%h/%b want 00/FF/FF/1", cnt_b, hex1_b, hex0_b, fault_b);
        else n_pass++;
        x = 1'b0; v = 1'b1; d = 1'b0;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h00, 8'hFF, 8'hFF, 1'b0})
            $display("FAIL fault_exit: got %h/%h/%h/%b want 00/FF/FF/0", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h02, 8'hFF, 8'hA4, 1'b0})
            $display("FAIL fault_reload: got %h/%h/%h/%b want 02/FF/A4/0", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        x = 1'b1; v = 1'b0;
        clk_cycle();
        tick = 1'b1;
        repeat (2) clk_cycle();
        tick = 1'b0;
        n_checks++;
        if ({cnt_a, hex0_a} !== {8'h04, 8'h99})
            $display("FAIL pre_reset: got %h/%h want 04/99", cnt_a, hex0_a);
        else n_pass++;
        rs = 1'b0;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a, fault_a} !== {8'h00, 8'hFF, 8'hFF, 1'b0})
            $display("FAIL mid_reset: got %h/%h/%h/%b want 00/FF/FF/0", cnt_a, hex1_a, hex0_a, fault_a);
        else n_pass++;
        rs = 1'b1;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a} !== {8'h06, 8'hFF, 8'h82})
            $display("FAIL same_phase_reload: got %h/%h/%h want 06/FF/82", cnt_a, hex1_a, hex0_a);
        else n_pass++;
        x = 1'b0; d = 1'b1;
        clk_cycle();
        stop = 1'b1;
        clk_cycle();
        rs = 1'b0;
        clk_cycle();
        n_checks++;
        if ({cnt_a, hex1_a, hex0_a} !== {8'h00, 8'hFF, 8'hFF})
            $display("FAIL hold_reset: got %h/%h/%h want 00/FF/FF", cnt_a, hex1_a, hex0_a);
        else n_pass++;
        rs = 1'b1; stop = 1'b0;
        clk_cycle();
        n_checks++;
        if ({cnt_b, hex1_b, hex0_b} !== {8'h12, 8'hF9, 8'hA4})
            $display("FAIL hold_reset_reload: got %h/%h/%h want 12/F9/A4", cnt_b, hex1_b, hex0_b);
        else n_pass++;
    endtask

    // Behavioural model: remaining time kept as a plain integer per instance.
    task automatic model_step();
        int hot;
        int ph;
        hot = int'(x) + int'(v) + int'(d);
        ph = x ? 1 : (v ? 2 : 3);
        for (int i = 0; i < 2; i++) begin
            if (!rs) begin
                m_mode[i] = M_IDLE; m_rem[i] = 0; m_ph[i] = 0; m_streak[i] = 0;
            end else if (hot != 1) begin
                if (m_streak[i] >= 1) begin
                    m_mode[i] = M_FAULT; m_rem[i] = 0; m_ph[i] = 0;
                end
                if (m_streak[i] < 2) m_streak[i]++;
            end else begin
                m_streak[i] = 0;
                if (m_mode[i] == M_FAULT) begin
                    m_mode[i] = M_IDLE;
                end else if (m_mode[i] == M_HOLD) begin
                    if (!stop) m_mode[i] = M_RUN;
                end else if (ph != m_ph[i]) begin
                    m_rem[i] = m_dur[i][ph]; m_ph[i] = ph; m_mode[i] = M_RUN;
                end else if (m_mode[i] == M_RUN) begin
                    if (stop && d) m_mode[i] = M_HOLD;
                    else if (tick && m_rem[i] > 0) m_rem[i]--;
                end
            end
        end
    endtask

    task automatic test_random();
        int cur_ph = 1;
        int bad_left = 0;
        logic [2:0] bad_pat;
        logic [7:0] e_cnt, e_h0, e_h1, g_cnt, g_h0, g_h1;
        logic e_f, g_f;
        for (int c = 0; c < 2000; c++) begin
            rs = (c == 0 || $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 11) == 0) cur_ph = int'($urandom_range(1, 3));
            if ($urandom_range(0, 14) == 0) stop = ~stop;
            if (bad_left == 0 && $urandom_range(0, 39) == 0) bad_left = int'($urandom_range(1, 3));
            if (bad_left > 0) begin
                case ($urandom_range(0, 4))
                    0: bad_pat = 3'b000;
                    1: bad_pat = 3'b110;
                    2: bad_pat = 3'b011;
                    3: bad_pat = 3'b101;
                    default: bad_pat = 3'b111;
                endcase
                {x, v, d} = bad_pat;
                tick = 1'b0;
                bad_left--;
            end else begin
                x = (cur_ph == 1); v = (cur_ph == 2); d = (cur_ph == 3);
                tick = 1'($urandom_range(0, 1));
            end
            model_step();
            clk_cycle();
            for (int i = 0; i < 2; i++) begin
                e_cnt = {4'(m_rem[i] / 10), 4'(m_rem[i] % 10)};
                e_f = (m_mode[i] == M_FAULT);
                if (m_mode[i] == M_RUN) begin
                    e_h0 = seg_tbl[m_rem[i] % 10];
                    e_h1 = (m_rem[i] / 10 == 0) ? 8'hFF : seg_tbl[m_rem[i] / 10];
                end else if (m_mode[i] == M_HOLD) begin
                    e_h0 = 8'hBF; e_h1 = 8'hBF;
                end else begin
                    e_h0 = 8'hFF; e_h1 = 8'hFF;
                end
                g_cnt = (i == 0) ? cnt_a : cnt_b;
                g_h0 = (i == 0) ? hex0_a : hex0_b;
                g_h1 = (i == 0) ? hex1_a : hex1_b;
                g_f = (i == 0) ? fault_a : fault_b;
                n_checks++;
                if ({g_cnt, g_h1, g_h0, g_f} !== {e_cnt, e_h1, e_h0, e_f})
                    $display("FAIL random c%0d dut%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, i,
                             g_cnt, g_h1, g_h0, g_f, e_cnt, e_h1, e_h0, e_f);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_phase_priority();
        test_red_two_digit();
        test_hold();
        test_fault();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
